// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam int         PS2_DATA_BITS = 8;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    // One decoded key event; "rel" marks a key break (F0 prefix).
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO. Head is always the oldest entry; storage clears on reset
// so the head reads zero while empty after reset.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  ps2_event_t push_data,
    input  logic       pop,
    output ps2_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 2 ** FIFO_BITS;

    ps2_event_t           mem [DEPTH];
    logic [FIFO_BITS:0]   wr_ptr;
    logic [FIFO_BITS:0]   rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {FIFO_BITS{1'b0}}});
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[FIFO_BITS-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[FIFO_BITS-1:0]] <= push_data;
                wr_ptr                     <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: input conditioning, frame FSM, E0/F0 pre-decoder and
// event FIFO feeding the keyboard matrix logic.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for start bit (strobe with data=0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd parity bit
// ST_STOP   | checking stop bit, classifying the byte
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2048,
    parameter int FIFO_BITS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    input  logic       ev_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic                     clk_s1, clk_s2, data_s1, data_s2;
    logic                     clk_filt, clk_filt_q, strobe;
    logic [FW-1:0]            filt_cnt;
    logic [TW-1:0]            to_cnt;
    logic                     timeout;
    ps2_state_t               state;
    logic [2:0]               bit_cnt;
    logic [PS2_DATA_BITS-1:0] shreg;
    logic                     par_bit;
    logic                     ext_f, rel_f;
    logic                     stop_strobe, parity_ok, byte_good, is_prefix;
    logic                     push, pop, fifo_full, fifo_empty;
    ps2_event_t               push_ev, head;

    // Two-flop synchronizers; lines idle high so reset them high to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
        end
    end

    // Run-length glitch filter on the clock, then a registered falling-edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt   <= '0;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            strobe     <= 1'b0;
        end else begin
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_cnt <= '0;
                clk_filt <= clk_s2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
            clk_filt_q <= clk_filt;
            strobe     <= clk_filt_q & ~clk_filt;
        end
    end

    // Inactivity counter, cleared by every strobe and saturating at TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      to_cnt <= '0;
        else if (strobe)                to_cnt <= '0;
        else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (to_cnt == TW'(TIMEOUT));

    // Stop-bit classification; push is combinational so the FIFO writes on the stop strobe.
    always_comb begin
        stop_strobe = strobe && (state == ST_STOP);
        parity_ok   = ^{shreg, par_bit};
        byte_good   = stop_strobe && data_s2 && parity_ok;
        is_prefix   = (shreg == PS2_EXT) || (shreg == PS2_BRK);
        push        = byte_good && !is_prefix;
        push_ev     = '{ext: ext_f, rel: rel_f, code: shreg};
    end

    assign pop = ev_valid && ev_ready;

    // Frame FSM, prefix flags and registered error/overflow pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ext_f      <= 1'b0;
            rel_f      <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            overflow   <= 1'b0;
            if (!strobe && timeout && state != ST_IDLE) begin
                state     <= ST_IDLE;
                err_frame <= 1'b1;
                ext_f     <= 1'b0;
                rel_f     <= 1'b0;
            end else if (strobe) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            err_frame <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data_s2, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= data_s2;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!data_s2 || !parity_ok) begin
                            err_frame  <= !data_s2;
                            err_parity <= data_s2;
                            ext_f      <= 1'b0;
                            rel_f      <= 1'b0;
                        end else if (shreg == PS2_EXT) begin
                            ext_f <= 1'b1;
                        end else if (shreg == PS2_BRK) begin
                            rel_f <= 1'b1;
                        end else begin
                            ext_f    <= 1'b0;
                            rel_f    <= 1'b0;
                            overflow <= fifo_full && !pop;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    ps2_event_fifo #(.FIFO_BITS(FIFO_BITS)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ev_valid   = !fifo_empty;
    assign ev_code    = head.code;
    assign ev_ext     = head.ext;
    assign ev_release = head.rel;

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver and scancode pre-decoder. It sits on the core side of the keyboard link driven by `user_io`, consuming its `ps2_kbd_clk`/`ps2_kbd_data` pair. It recovers 11-bit PS/2 frames, folds `E0`/`F0` prefixes into flags, and presents complete key events through a small show-ahead FIFO to the TRS-80 keyboard matrix logic.

## Interface
Parameters:
- `FILTER_LEN`, default 4: number of consecutive identical synchronized samples required before the filtered PS/2 clock changes state.
- `TIMEOUT`, default 2048: number of `clk` cycles without a PS/2 falling edge after which a partial frame is aborted.
- `FIFO_BITS`, default 2: log2 of the event FIFO depth, so the default depth is 4.

Ports:
- `clk`  in  1  system clock; must be at least 16 times the PS/2 clock rate.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk_in`  in  1  PS/2 clock from `user_io`; asynchronous to `clk`.
- `ps2_data_in`  in  1  PS/2 data from `user_io`; asynchronous to `clk`.
- `ev_valid`  out  1  the FIFO head holds an event.
- `ev_code`  out  8  scancode at the FIFO head.
- `ev_ext`  out  1  the head event was preceded by `E0`.
- `ev_release`  out  1  the head event was preceded by `F0` (key break).
- `ev_ready`  in  1  consumer accepts the head event.
- `err_parity`  out  1  one-cycle pulse: parity error detected.
- `err_frame`  out  1  one-cycle pulse: bad start bit, bad stop bit, or timeout.
- `overflow`  out  1  one-cycle pulse: an event was dropped because the FIFO was full.

## Operation
- **Input conditioning:**
  - Both inputs pass through a 2-flop synchronizer.
  - The clock then passes through a `FILTER_LEN` run-length filter.
  - A falling edge of the filtered clock is the sample strobe; data is sampled from the synchronized data line on that strobe.
- **Frame FSM.** States are IDLE, DATA, PARITY, STOP.
  - IDLE → DATA on a strobe with data=0. A strobe with data=1 in IDLE pulses `err_frame` and stays in IDLE.
  - DATA: shift data in LSB first; the 3-bit bit counter goes 0..7. → PARITY after the 8th bit.
  - PARITY: capture the parity bit. → STOP.
  - STOP: a frame is good when stop=1 and the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
    - Stop=0 → `err_frame`.
    - Otherwise, bad parity → `err_parity`.
    - Either error clears both prefix flags.
    - All cases → IDLE.
- **Timeout:**
  - A counter clears on every strobe and saturates at `TIMEOUT`.
  - On reaching `TIMEOUT` in any state other than IDLE: → IDLE, pulse `err_frame`, clear both prefix flags.
- **Pre-decoder** (runs on each good byte):
  - `E0` sets `ext_f`.
  - `F0` sets `rel_f`.
  - Any other byte pushes the event {`ext_f`, `rel_f`, byte} and then clears both flags.
- **FIFO:**
  - Depth `2**FIFO_BITS`; pointers are `FIFO_BITS+1` bits wide and wrap naturally.
  - Full means the pointers differ only in their MSB; empty means the pointers are equal.
  - A push when full drops the event, pulses `overflow`, and still clears the flags.
  - Pop happens when `ev_valid && ev_ready`.
  - A simultaneous push and pop when full is accepted: the pop frees the slot in the same cycle.
- **Reset values:**
  - FSM is in IDLE.
  - Pointers, flags and counters are 0.
  - `ev_valid`, `err_parity`, `err_frame` and `overflow` are 0.
  - `ev_code`, `ev_ext` and `ev_release` read 0, because the FIFO storage is cleared on reset.
  - Reset mid-frame discards the partial byte.

## Timing
- Strobe latency from an input falling edge is 2 synchronizer cycles plus `FILTER_LEN` cycles, plus 1 cycle for the edge register.
- On the stop-bit strobe cycle, the byte is classified; in the same cycle, an error pulse is registered or the push is performed.
- `ev_valid` rises 1 cycle after the push, i.e. 1 cycle after the stop-bit strobe.
- All outputs are registered.
- `ev_*` are taken directly from the FIFO head and are stable while `ev_valid && !ev_ready`.
- Pop takes effect at the clock edge; the next entry, or `ev_valid`=0, appears the following cycle.
- Error and overflow pulses are exactly 1 cycle wide. At most one of the three pulses fires per frame.

## Structure
- Package `ps2_pkg`:
  - Frame constants: `PS2_DATA_BITS`=8.
  - Prefix codes: `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0.
  - FSM state enum.
  - Event struct {ext, release, code[7:0]}, 10 bits.
- Sub-module `ps2_event_fifo` (parameter `FIFO_BITS`, 10-bit word, show-ahead, push/pop/full/empty).
- The synchronizer, filter, FSM and pre-decoder stay in the top level.

## Test plan
- **Good frame:** send frame for 8'h1C (odd parity bit=0) → one event: code=1C, ext=0, release=0, `ev_valid` 1 cycle after stop strobe; no error pulses.
- **Prefixed sequence:** send E0,F0,75 → exactly one event: code=75, ext=1, release=1. A following plain 1C → ext=0, release=0.
- **Parity fault:** F0 followed by 1C with its parity bit flipped → `err_parity` pulse, no event, flags cleared. A subsequent 1C → release=0.
- **Timeout:** stop the clock after 4 data bits for 2048+ cycles → `err_frame` pulse and FSM back in IDLE. Then a full good frame for 29 → event code=29.
- **Overflow:** `ev_ready`=0, send 5 plain codes 01..05 → FIFO holds 01..04 and the 5th produces an `overflow` pulse. Raise `ev_ready` → events drain in order 01,02,03,04, then `ev_valid`=0.
- **Reset mid-frame:** assert `reset` after 3 data bits → all outputs 0. The next full frame for 5A decodes correctly.
